// File: rtl/tinyenc_stream.sv
// tinyenc_stream: packs a byte stream into 32-bit blocks for the block encryptor
// and streams the ciphertext block back out as four bytes.
module tinyenc_stream #(
    parameter logic [7:0] PAD = 8'h00
) (
    input  logic        clk,
    input  logic        prstb,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        enc_req,
    output logic [31:0] enc_wdata,
    input  logic        enc_ack,
    input  logic [31:0] enc_rdata,
    output logic [15:0] blk_count
);
    typedef enum logic [1:0] {ST_FILL, ST_REQ, ST_WAIT, ST_DRAIN} state_t;
    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d, k_q, k_d;
    logic [31:0] wdata_q, wdata_d, obuf_q, obuf_d;
    logic [15:0] blk_q, blk_d;
    logic        last_q, last_d, seen_q, seen_d, run_q;
    logic        xfer_in, xfer_out, fill_done, capture, drain_done;
    assign xfer_in    = s_valid && s_ready;
    assign xfer_out   = m_valid && m_ready;
    assign fill_done  = xfer_in && (cnt_q == 2'd3 || s_last);
    assign capture    = state_q == ST_WAIT && enc_ack;
    assign drain_done = xfer_out && k_q == 2'd3;
    always_ff @(posedge clk or negedge prstb) begin
        if (!prstb) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            k_q     <= '0;
            wdata_q <= '0;
            obuf_q  <= '0;
            blk_q   <= '0;
            last_q  <= 1'b0;
            seen_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            wdata_q <= wdata_d;
            obuf_q  <= obuf_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
            seen_q  <= seen_d;
            run_q   <= 1'b1;
        end
    end
    // The encryptor has started once ack was seen idle and then sampled low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  state_d = fill_done ? ST_REQ : ST_FILL;
            ST_REQ:   state_d = (seen_q && !enc_ack) ? ST_WAIT : ST_REQ;
            ST_WAIT:  state_d = enc_ack ? ST_DRAIN : ST_WAIT;
            default:  state_d = drain_done ? ST_FILL : ST_DRAIN;
        endcase
    end
    always_comb begin
        cnt_d = fill_done ? 2'd0 : cnt_q + 2'(xfer_in);
        for (int i = 0; i < 4; i++)
            wdata_d[8*i +: 8] = (xfer_in && cnt_q == 2'(i)) ? s_data :
                                (fill_done && 2'(i) > cnt_q) ? PAD : wdata_q[8*i +: 8];
        last_d = fill_done ? s_last : drain_done ? 1'b0 : last_q;
        seen_d = (state_q == ST_REQ) && (seen_q || enc_ack);
        obuf_d = capture ? enc_rdata : obuf_q;
        blk_d  = blk_q + 16'(capture);
        k_d    = k_q + 2'(xfer_out);
    end
    always_comb begin
        s_ready   = run_q && state_q == ST_FILL;
        m_valid   = state_q == ST_DRAIN;
        m_data    = obuf_q[8*k_q +: 8];
        m_last    = m_valid && last_q && k_q == 2'd3;
        enc_req   = state_q == ST_REQ;
        enc_wdata = wdata_q;
        blk_count = blk_q;
    end
endmodule
